msftdvip_axi_fifo_ext: RTL

Parametrised synchronous FIFO, successor to the basic AXI-channel FIFO.
- Supports any depth, including non-power-of-two.
- Uses valid/ready handshake on both sides.
- Adds fill-level, almost-full/almost-empty flags, synchronous flush and a high-water-mark monitor.
- Sits on AXI channel paths inside the CHERI subsystem interconnect, where buffer sizing is tuned per channel.

---
 rtl/msftdvip_axi_fifo_ext.sv | 90 +++++++++
 1 files changed

// File: rtl/msftdvip_axi_fifo_ext.sv
// Parametrised synchronous valid/ready FIFO for AXI channel paths.
// Provides fill level, almost-full/almost-empty flags, flush and a high-water-mark monitor.
module msftdvip_axi_fifo_ext #(
    parameter int DEPTH         = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    localparam int LVL_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wm_clr_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [LVL_W-1:0]      level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [LVL_W-1:0]      max_level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("msftdvip_axi_fifo_ext: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
        $error("msftdvip_axi_fifo_ext: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
        $error("msftdvip_axi_fifo_ext: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;

    // Handshake status comes only from the level register, never from the request inputs.
    assign wr_ready_o     = (level_o != LVL_W'(DEPTH));
    assign rd_valid_o     = (level_o != '0);
    assign wr_fire        = wr_valid_i & wr_ready_o;
    assign rd_fire        = rd_valid_o & rd_ready_i;
    assign rd_data_o      = rd_valid_o ? mem[rd_ptr] : '0;
    assign almost_full_o  = (level_o >= LVL_W'(AFULL_THRESH));
    assign almost_empty_o = (level_o <= LVL_W'(AEMPTY_THRESH));

    // Storage is deliberately left unreset; a flushed write is simply never stored.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && wr_fire) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Explicit wrap compare keeps non-power-of-two depths correct.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   level_o <= level_o + LVL_W'(1);
                2'b01:   level_o <= level_o - LVL_W'(1);
                default: level_o <= level_o;
            endcase
        end
    end

    // High-water mark trails level by one cycle and survives a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || wm_clr_i) begin
            max_level_o <= '0;
        end else if (level_o > max_level_o) begin
            max_level_o <= level_o;
        end
    end

endmodule
